// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle between the issue stage, the shift sequencer and writeback.
// Master drives requests and consumes responses; slave is the sequencer.
interface shift_seq_ctrl_if #(
    parameter int L1 = 8,
    parameter int L2 = 8
);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    op;
    logic [L1-1:0] in1;
    logic [L2-1:0] in2;
    logic          resp_valid;
    logic          resp_ready;
    logic [L1-1:0] out;
    logic          err;

    modport master (
        output req_valid, op, in1, in2, resp_ready,
        input  req_ready, resp_valid, out, err
    );

    modport slave (
        input  req_valid, op, in1, in2, resp_ready,
        output req_ready, resp_valid, out, err
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: shifts up to MAXSTEP positions per cycle until the amount is consumed.
// Optional macro SHIFT_SEQ_CTRL_FAST_CLAMP_EN resolves amounts >= L1 directly to DONE.
module shift_seq_ctrl #(
    parameter int L1      = 8,
    parameter int L2      = 8,
    parameter int MAXSTEP = 4
) (
    input logic             clk,
    input logic             rst,
    shift_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(L1 + 1);
    localparam int WC = (L2 > 32) ? L2 : 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [L1-1:0] data_q;
    logic [L1-1:0] out_q;
    logic [CW-1:0] rem_q;
    logic [1:0]    op_q;
    logic          err_q;

    logic [CW-1:0] eff_in;
    logic [CW-1:0] step;
    logic [CW-1:0] rem_n;
    logic [L1-1:0] data_n;
    logic          direct_done;
    logic [L1-1:0] direct_out;

    // Clamp is evaluated at full amount width so large in2 values never alias after truncation.
    function automatic logic [CW-1:0] clamp_amt(input logic [L2-1:0] amt);
        logic [WC-1:0] w;
        w = WC'(amt);
        if (w >= WC'(L1)) return CW'(L1);
        return CW'(amt);
    endfunction

    function automatic logic [CW-1:0] step_amt(input logic [CW-1:0] rem);
        logic [CW-1:0] ms;
        ms = CW'(MAXSTEP);
        return (rem < ms) ? rem : ms;
    endfunction

    // SRA relies on the data MSB staying equal to the latched operand sign across steps.
    function automatic logic [L1-1:0] shift_by(input logic [1:0] o, input logic [L1-1:0] d,
                                                input logic [CW-1:0] n);
        logic signed [L1-1:0] sd;
        sd = $signed(d) >>> n;
        case (o)
            2'b00:   return d >> n;
            2'b01:   return d << n;
            default: return $unsigned(sd);
        endcase
    endfunction

    always_comb begin
        eff_in      = clamp_amt(bus.in2);
        step        = step_amt(rem_q);
        rem_n       = rem_q - step;
        data_n      = shift_by(op_q, data_q, step);
        direct_done = (bus.op == 2'b11) || (eff_in == '0);
        direct_out  = bus.in1;
`ifdef SHIFT_SEQ_CTRL_FAST_CLAMP_EN
        if ((bus.op != 2'b11) && (WC'(bus.in2) >= WC'(L1))) begin
            direct_done = 1'b1;
            direct_out  = (bus.op == 2'b10) ? {L1{bus.in1[L1-1]}} : '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.req_valid) state_n = direct_done ? DONE : SHIFT;
            SHIFT:   if (rem_n == '0) state_n = DONE;
            DONE:    if (bus.resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            out_q  <= '0;
            rem_q  <= '0;
            op_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q   <= bus.op;
                        data_q <= bus.in1;
                        rem_q  <= eff_in;
                        err_q  <= (bus.op == 2'b11);
                        if (direct_done) out_q <= direct_out;
                    end
                end
                SHIFT: begin
                    data_q <= data_n;
                    rem_q  <= rem_n;
                    if (rem_n == '0) out_q <= data_n;
                end
                default: ;
            endcase
        end
    end

    // err is gated by DONE so a stale flag never leaks outside a response.
    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == DONE);
        bus.err        = (state == DONE) && err_q;
        bus.out        = out_q;
    end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with an arithmetic reference model and a per-cycle checker.
module tb_shift_seq_ctrl;
    localparam int L1      = 8;
    localparam int L2      = 8;
    localparam int MAXSTEP = 4;
`ifdef SHIFT_SEQ_CTRL_FAST_CLAMP_EN
    localparam int CLAMP_LAT = 1;
`else
    localparam int CLAMP_LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;
    bit   pending = 1'b0;
    int   acc = 0;
    int   m_lat = 0;
    logic [7:0] m_out = '0;
    logic       m_err = 1'b0;

    shift_seq_ctrl_if #(.L1(L1), .L2(L2)) bus ();

    shift_seq_ctrl #(.L1(L1), .L2(L2), .MAXSTEP(MAXSTEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int eff_of(input logic [7:0] b);
        return (int'(b) >= L1) ? L1 : int'(b);
    endfunction

    function automatic logic [7:0] model_out(input logic [1:0] o, input logic [7:0] a,
                                             input logic [7:0] b);
        logic signed [7:0] s;
        int e;
        e = eff_of(b);
        s = a;
        case (o)
            2'b00:   return a >> e;
            2'b01:   return a << e;
            2'b10:   return s >>> e;
            default: return a;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [7:0] b);
        int e;
        e = eff_of(b);
        if (o == 2'b11 || e == 0) return 1;
`ifdef SHIFT_SEQ_CTRL_FAST_CLAMP_EN
        if (int'(b) >= L1) return 1;
`endif
        return 1 + (e + MAXSTEP - 1) / MAXSTEP;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("rdy_vld_exclusive", bus.resp_valid & bus.req_ready, 0);
            check("err_qualified", bus.err & ~bus.resp_valid, 0);
            if (!rst) check("req_ready", bus.req_ready, !pending);
            if (pending) begin
                check("resp_valid_timing", bus.resp_valid, (cyc >= acc + m_lat - 1));
                if (bus.resp_valid) begin
                    check("out", bus.out, m_out);
                    check("err", bus.err, m_err);
                end
            end else begin
                check("no_stale_resp", bus.resp_valid, 0);
            end
        end
    end

    task automatic run_req(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] xo, input logic xe, input int xl, input int hold);
        int n;
        check("model_out", model_out(o, a, b), xo);
        check("model_err", (o == 2'b11), xe);
        check("model_lat", model_lat(o, b), xl);
        bus.op = o;
        bus.in1 = a;
        bus.in2 = b;
        bus.req_valid = 1'b1;
        bus.resp_ready = (hold == 0);
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("accept_timeout", 1, 0);
        @(posedge clk); #1;
        pending = 1'b1;
        acc = cyc;
        m_out = model_out(o, a, b);
        m_err = (o == 2'b11);
        m_lat = model_lat(o, b);
        bus.req_valid = 1'b0;
        bus.op = 2'($urandom);
        bus.in1 = 8'($urandom);
        bus.in2 = 8'($urandom);
        n = 0;
        while (!bus.resp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("resp_timeout", 1, 0);
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                bus.req_valid = 1'b1;
                bus.op = 2'b01;
                bus.in1 = 8'hAA;
                bus.in2 = 8'd1;
            end else begin
                bus.req_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        pending = 1'b0;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b0;
        bus.op = '0;
        bus.in1 = '0;
        bus.in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_req_ready", bus.req_ready, 1);
        check("reset_resp_valid", bus.resp_valid, 0);
        check("reset_out", bus.out, 0);
        check("reset_err", bus.err, 0);

        run_req(2'b00, 8'hB4, 8'd3,   8'h16, 1'b0, 2, 0);
        run_req(2'b10, 8'hB4, 8'd6,   8'hFE, 1'b0, 3, 0);
        run_req(2'b01, 8'h0F, 8'd5,   8'hE0, 1'b0, 3, 0);
        run_req(2'b01, 8'hFF, 8'd200, 8'h00, 1'b0, CLAMP_LAT, 0);
        run_req(2'b10, 8'h80, 8'd200, 8'hFF, 1'b0, CLAMP_LAT, 0);
        run_req(2'b00, 8'h3C, 8'd8,   8'h00, 1'b0, CLAMP_LAT, 0);
        run_req(2'b11, 8'h5A, 8'd2,   8'h5A, 1'b1, 1, 0);
        run_req(2'b00, 8'h3C, 8'd0,   8'h3C, 1'b0, 1, 0);
        run_req(2'b10, 8'h74, 8'd2,   8'h1D, 1'b0, 2, 0);
        run_req(2'b01, 8'h01, 8'd4,   8'h10, 1'b0, 2, 5);
        run_req(2'b11, 8'hC3, 8'd9,   8'hC3, 1'b1, 1, 5);
        run_req(2'b01, 8'h81, 8'd7,   8'h80, 1'b0, 3, 0);

        // Reset one step into an SRL 0xB4 by 7; the response must never surface.
        bus.op = 2'b00;
        bus.in1 = 8'hB4;
        bus.in2 = 8'd7;
        bus.req_valid = 1'b1;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        pending = 1'b1;
        acc = cyc;
        m_out = model_out(2'b00, 8'hB4, 8'd7);
        m_err = 1'b0;
        m_lat = model_lat(2'b00, 8'd7);
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        pending = 1'b0;
        check("midreset_req_ready", bus.req_ready, 1);
        check("midreset_resp_valid", bus.resp_valid, 0);
        check("midreset_out", bus.out, 0);
        check("midreset_err", bus.err, 0);
        repeat (4) begin
            @(posedge clk); #1;
        end

        run_req(2'b00, 8'h80, 8'd1, 8'h40, 1'b0, 2, 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle shift sequencer. It applies a shift of up to MAXSTEP bit positions per cycle, repeating until the requested amount is reached.
- It replaces a full-width single-cycle barrel shift where area or timing is tight.
- It accepts one request at a time over a valid/ready handshake and returns the result over a second valid/ready handshake.
- It sits between an ALU/issue stage and its writeback.

Parameters:
- L1, 8: data width of in1 and out.
- L2, 8: width of the shift amount in2.
- MAXSTEP, 4: maximum bit positions shifted per cycle. Legal range is 1..L1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- op  input  2  00 SRL, 01 SLL, 10 SRA, 11 reserved.
- in1  input  L1  operand.
- in2  input  L2  shift amount, unsigned.
- resp_valid  output  1  result present.
- resp_ready  input  1  consumer accepts the result.
- out  output  L1  shifted result.
- err  output  1  result came from a reserved op; qualified by resp_valid.

Behaviour:
- Reset: synchronous; rst high at a clock edge forces the following.
  - State goes to IDLE.
  - req_ready=1, resp_valid=0, out=0, err=0.
  - The internal data and remaining-count registers clear to 0.
  - Reset dominates every other input, including mid-SHIFT and in DONE. Any in-flight request is dropped with no response.
- States:
  - IDLE: req_ready=1. Acceptance happens when req_valid&&req_ready at edge T.
    - op, in1 and eff are latched, where eff = min(in2, L1).
    - Counter width is $clog2(L1+1). The clamp is computed at full L2 width before truncation.
    - op=11: go to DONE with out=in1 and err=1.
    - eff=0: go to DONE with out=in1 and err=0.
    - Otherwise: go to SHIFT.
  - SHIFT: req_ready=0. Each cycle:
    - step = min(remaining, MAXSTEP).
    - data is shifted by step. SRL zero-fills on the left, SLL zero-fills on the right, SRA fills with the latched in1[L1-1].
    - remaining -= step.
    - When the updated remaining is 0, go to DONE on that same edge.
  - DONE: resp_valid=1, req_ready=0.
    - out and err are held stable while resp_ready=0.
    - On resp_valid&&resp_ready go to IDLE. resp_valid drops on the next cycle.
- Latency: resp_valid is first high in cycle T+1+ceil(eff/MAXSTEP). Reserved op and eff=0 give T+1.
- Throughput: one request in flight. A new request can be accepted no earlier than the cycle after the response handshake, because req_ready is high only in IDLE.
- Ignored inputs: req_valid while not in IDLE is ignored, and the operand is not sampled. Input values outside the acceptance edge have no effect.
- Clamping: in2 ≥ L1 is equivalent to in2 = L1.
  - SRL and SLL give 0.
  - SRA gives all bits equal to the sign bit.
- out: registered. It keeps its last value outside DONE and is only meaningful while resp_valid=1.
- Invariants:
  - resp_valid and req_ready are never high together.
  - err=1 only with resp_valid=1.

Optional Feature:
- SHIFT_SEQ_CTRL_FAST_CLAMP_EN
- Defined: on acceptance with op≠11 and in2 ≥ L1, the controller skips SHIFT and goes straight to DONE at T+1.
  - SRL and SLL produce out=0.
  - SRA produces out={L1{in1[L1-1]}}.
  - err=0.
- Undefined: these requests iterate through SHIFT with eff=L1. The result is identical; only latency differs.

Test Plan (L1=8, L2=8, MAXSTEP=4, request accepted at edge T):
- SRL, in1=0xB4, in2=3 → out=0x16, err=0; resp_valid first high at T+2.
- SRA, in1=0xB4, in2=6 → out=0xFE; resp_valid at T+3. SLL, in1=0x0F, in2=5 → out=0xE0 at T+3.
- SLL, in1=0xFF, in2=200 → out=0x00. resp_valid at T+3 without the macro, T+1 with SHIFT_SEQ_CTRL_FAST_CLAMP_EN. Repeat with SRA, in1=0x80 → out=0xFF.
- op=11, in1=0x5A, in2=2 → out=0x5A, err=1 at T+1. Then in2=0 with op=00 → out=in1, err=0 at T+1.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE → out, err and resp_valid stay stable and req_ready stays 0. A req_valid pulse during this window is not accepted. Raising resp_ready → IDLE on the next cycle, and the next request is accepted.
- Reset: assert rst for 1 cycle mid-SHIFT (SRL 0xB4 by 7, after 1 step) → the next cycle shows IDLE, req_ready=1, resp_valid=0, out=0, and no stale response ever appears. A subsequent SRL 0x80 by 1 → 0x40 at T+2.
